// File: rtl/hall_sensor_emulator.sv
// rtl/hall_sensor_emulator.sv - PWM-driven motor plant that regenerates quadrature Hall outputs
// Slew-limited speed inertia is enabled by defining HALL_INERTIA_EN.
module hall_sensor_emulator #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int FREQ_WIDTH  = 8,
    parameter int MAX_FREQ_HZ = 200,
    parameter int WIN_LOG2    = 16,
    parameter int SLEW_STEP   = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en_in,
    input  logic                  dir_in,
    output logic                  sa,
    output logic                  sb,
    output logic                  dir_model,
    output logic [FREQ_WIDTH-1:0] freq_model
);
    localparam int QUARTER = CLK_FREQ_HZ / 4;
    localparam int ACC_W   = $clog2(QUARTER + (1 << FREQ_WIDTH) + 1);
    localparam int PROD_W  = WIN_LOG2 + 1 + FREQ_WIDTH;
    localparam logic [ACC_W-1:0]      QUARTER_C = ACC_W'(QUARTER);
    localparam logic [FREQ_WIDTH-1:0] MAX_C     = FREQ_WIDTH'(MAX_FREQ_HZ);

    if (MAX_FREQ_HZ >= QUARTER || MAX_FREQ_HZ > (1 << FREQ_WIDTH) - 1 || SLEW_STEP < 1) begin : g_bad_cfg
        $error("hall_sensor_emulator: invalid parameter set");
    end

    logic                  en_meta_q, en_meta_d, en_s_q, en_s_d;
    logic [WIN_LOG2-1:0]   win_cnt_q, win_cnt_d;
    logic [WIN_LOG2:0]     high_cnt_q, high_cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [FREQ_WIDTH-1:0] freq_q, freq_d;
    logic                  dir_q, dir_d;
    logic                  sa_q, sa_d, sb_q, sb_d;

    logic                  wrap;
    logic [WIN_LOG2:0]     h;
    logic [PROD_W-1:0]     prod, prod_sh;
    logic [FREQ_WIDTH-1:0] tgt, stepped;
    logic [ACC_W-1:0]      sum;

    assign wrap    = &win_cnt_q;
    assign h       = high_cnt_q + (WIN_LOG2 + 1)'(en_s_q);
    assign prod    = PROD_W'(h) * PROD_W'(MAX_FREQ_HZ);
    assign prod_sh = prod >> WIN_LOG2;
    assign tgt     = (prod_sh > PROD_W'(MAX_FREQ_HZ)) ? MAX_C : prod_sh[FREQ_WIDTH-1:0];
    assign sum     = acc_q + ACC_W'(freq_q);

`ifdef HALL_INERTIA_EN
    localparam logic [FREQ_WIDTH-1:0] SLEW_C = FREQ_WIDTH'(SLEW_STEP);

    // Move toward the target by at most one slew step, landing exactly on it when close.
    always_comb begin
        stepped = tgt;
        if (tgt > freq_q) begin
            if (tgt - freq_q > SLEW_C) stepped = freq_q + SLEW_C;
        end else begin
            if (freq_q - tgt > SLEW_C) stepped = freq_q - SLEW_C;
        end
    end
`else
    assign stepped = tgt;
`endif

    always_comb begin
        en_meta_d  = en_in;
        en_s_d     = en_meta_q;
        win_cnt_d  = win_cnt_q + WIN_LOG2'(1);
        high_cnt_d = wrap ? '0 : h;
        freq_d     = wrap ? stepped : freq_q;
        dir_d      = (freq_q == '0) ? dir_in : dir_q;
        acc_d      = sum;
        sa_d       = sa_q;
        sb_d       = sb_q;
        // Gray-code step: forward rotates 00->10->11->01, reverse walks it backwards.
        if (sum >= QUARTER_C) begin
            acc_d = sum - QUARTER_C;
            sa_d  = dir_q ? ~sb_q : sb_q;
            sb_d  = dir_q ? sa_q  : ~sa_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_meta_q  <= 1'b0;
            en_s_q     <= 1'b0;
            win_cnt_q  <= '0;
            high_cnt_q <= '0;
            acc_q      <= '0;
            freq_q     <= '0;
            dir_q      <= 1'b1;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
        end else begin
            en_meta_q  <= en_meta_d;
            en_s_q     <= en_s_d;
            win_cnt_q  <= win_cnt_d;
            high_cnt_q <= high_cnt_d;
            acc_q      <= acc_d;
            freq_q     <= freq_d;
            dir_q      <= dir_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
        end
    end

    assign sa         = sa_q;
    assign sb         = sb_q;
    assign dir_model  = dir_q;
    assign freq_model = freq_q;

endmodule

// File: tb/tb_hall_sensor_emulator.sv
// tb/tb_hall_sensor_emulator.sv - directed bench with a cycle model of the emulated motor plant
module tb_hall_sensor_emulator;
    localparam int CLK_HZ  = 4000;
    localparam int FW      = 8;
    localparam int MAXF    = 100;
    localparam int WL      = 8;
    localparam int SLEW    = 10;
    localparam int WIN     = 1 << WL;
    localparam int QUARTER = CLK_HZ / 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          en_in   = 1'b0;
    logic          dir_in  = 1'b1;
    logic          sa, sb, dir_model;
    logic [FW-1:0] freq_model;

    int total = 0;
    int bad   = 0;
    bit check_on = 1'b0;

    hall_sensor_emulator #(
        .CLK_FREQ_HZ(CLK_HZ), .FREQ_WIDTH(FW), .MAX_FREQ_HZ(MAXF),
        .WIN_LOG2(WL), .SLEW_STEP(SLEW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en_in(en_in), .dir_in(dir_in),
        .sa(sa), .sb(sb), .dir_model(dir_model), .freq_model(freq_model)
    );

    always #5 clk = ~clk;

    // Plant model: integer speed, accumulator and a quadrature phase index 0..3.
    int m_meta, m_ens, m_win, m_high, m_freq, m_dir, m_acc, m_ph;

    function automatic logic [1:0] ph_bits(int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int bits_ph(logic [1:0] b);
        case (b)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int step_to(int cur, int tgt);
`ifdef HALL_INERTIA_EN
        if (tgt > cur + SLEW) return cur + SLEW;
        if (tgt < cur - SLEW) return cur - SLEW;
`endif
        return tgt;
    endfunction

    task automatic model_reset();
        m_meta = 0; m_ens = 0; m_win = 0; m_high = 0;
        m_freq = 0; m_dir = 1; m_acc = 0; m_ph = 0;
    endtask

    task automatic model_clock();
        int n_freq, n_high, n_acc, n_ph, n_dir, hh, tgt, sum;
        n_freq = m_freq;
        n_ph   = m_ph;
        if (m_win == WIN - 1) begin
            hh  = m_high + m_ens;
            tgt = (hh * MAXF) / WIN;
            if (tgt > MAXF) tgt = MAXF;
            n_freq = step_to(m_freq, tgt);
            n_high = 0;
        end else begin
            n_high = m_high + m_ens;
        end
        sum = m_acc + m_freq;
        if (sum >= QUARTER) begin
            n_acc = sum - QUARTER;
            n_ph  = (m_dir != 0) ? (m_ph + 1) % 4 : (m_ph + 3) % 4;
        end else begin
            n_acc = sum;
        end
        n_dir  = (m_freq == 0) ? int'(dir_in) : m_dir;
        m_ens  = m_meta;
        m_meta = int'(en_in);
        m_win  = (m_win + 1) % WIN;
        m_high = n_high;
        m_freq = n_freq;
        m_acc  = n_acc;
        m_ph   = n_ph;
        m_dir  = n_dir;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_clock();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_on) begin
                total++;
                if ({sa, sb} !== ph_bits(m_ph) || dir_model !== 1'(m_dir) || freq_model !== FW'(m_freq)) begin
                    bad++;
                    $display("FAIL cycle_model: sa,sb,dir,freq got %b%b,%b,%0d want %b,%0d,%0d",
                             sa, sb, dir_model, freq_model, ph_bits(m_ph), m_dir, m_freq);
                end
            end
        end
    end

    // Edge monitor: classifies every sa/sb change and measures sa rising-edge spacing.
    logic [1:0] prev_ab = 2'b00;
    int fwd = 0, rev = 0, jump = 0;
    int mon_cyc = 0, last_rise = 0, sa_gap = 0;

    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if ({sa, sb} !== prev_ab) begin
                if (bits_ph({sa, sb}) == (bits_ph(prev_ab) + 1) % 4)      fwd++;
                else if (bits_ph({sa, sb}) == (bits_ph(prev_ab) + 3) % 4) rev++;
                else                                                     jump++;
            end
            if (sa === 1'b1 && prev_ab[1] === 1'b0) begin
                sa_gap    = mon_cyc - last_rise;
                last_rise = mon_cyc;
            end
            prev_ab = {sa, sb};
        end
    end

    task automatic clear_mon();
        fwd = 0; rev = 0; jump = 0;
    endtask

    task automatic chk(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic run(int n, bit toggle);
        repeat (n) begin
            @(negedge clk);
            if (toggle) en_in = ~en_in;
        end
    endtask

    // Ramp from a fresh reset release with en_in held high; the first window loses
    // two cycles to the synchroniser, so its raw target is 254*100/256 = 99.
    task automatic ramp_from_release(string tag);
        int exp1[12];
`ifdef HALL_INERTIA_EN
        exp1 = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 100, 100};
`else
        exp1 = '{99, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
`endif
        for (int k = 0; k < 12; k++) begin
            run(WIN, 1'b0);
            chk($sformatf("%s_win%0d_freq", tag, k + 1), int'(freq_model), exp1[k]);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_sa", int'(sa), 0);
        chk("reset_sb", int'(sb), 0);
        chk("reset_dir", int'(dir_model), 1);
        chk("reset_freq", int'(freq_model), 0);
        check_on = 1'b1;

        reset_n = 1'b1;
        clear_mon();
        run(3 * WIN, 1'b0);
        chk("idle_freq", int'(freq_model), 0);
        chk("idle_edges", fwd + rev + jump, 0);

        reset_n = 1'b0;
        run(2, 1'b0);
        reset_n = 1'b1;
        en_in   = 1'b1;
        ramp_from_release("ramp");

        clear_mon();
        run(400, 1'b0);
        chk("full_fwd_steps", fwd, 40);
        chk("full_rev_steps", rev, 0);
        chk("full_jumps", jump, 0);
        chk("full_sa_period", sa_gap, 40);

        run(8 * WIN, 1'b1);
        chk("half_freq", int'(freq_model), 50);
        chk("half_sa_period", sa_gap, 80);

        en_in = 1'b1;
        run(7 * WIN, 1'b0);
        chk("back_to_full", int'(freq_model), 100);

        dir_in = 1'b0;
        run(2 * WIN, 1'b0);
        chk("rev_held_dir", int'(dir_model), 1);
        chk("rev_held_freq", int'(freq_model), 100);
        en_in = 1'b0;
        run(12 * WIN, 1'b0);
        chk("stopped_freq", int'(freq_model), 0);
        chk("stopped_dir", int'(dir_model), 0);
        clear_mon();
        en_in = 1'b1;
        run(3 * WIN, 1'b0);
        chk("restart_fwd", fwd, 0);
        chk("restart_jumps", jump, 0);
        chk("restart_rev_seen", int'(rev > 0), 1);

        dir_in = 1'b1;
        run(300, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_sa", int'(sa), 0);
        chk("midreset_sb", int'(sb), 0);
        chk("midreset_dir", int'(dir_model), 1);
        chk("midreset_freq", int'(freq_model), 0);
        @(negedge clk);
        reset_n = 1'b1;
        ramp_from_release("recover");

        check_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
